rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3, the maximum consecutive cycles a valid LSU request may be refused.
REQ-002 SHALL have clk_i  input  1  rising-edge clock; the block has one clock.
REQ-003 SHALL have rst_ni  input  1  reset, synchronous and active-low.
REQ-004 SHALL have alu_valid_i  input  1  ALU writeback request.
REQ-005 SHALL have alu_ready_o  output  1  ALU request accepted this cycle.
REQ-006 SHALL have alu_rd_i  input  5  ALU destination register.
REQ-007 SHALL have alu_data_i  input  32  ALU result.
REQ-008 SHALL have lsu_valid_i  input  1  load-data writeback request.
REQ-009 SHALL have lsu_ready_o  output  1  LSU request accepted this cycle.
REQ-010 SHALL have lsu_rd_i  input  5  load destination register.
REQ-011 SHALL have lsu_data_i  input  32  load data.
REQ-012 SHALL have load_issue_i  input  1  load issued; marks its rd pending.
REQ-013 SHALL have load_issue_rd_i  input  5  destination register of the issued load.
REQ-014 SHALL have rs1_addr_i / rs2_addr_i  input  5 each  decode-stage source registers.
REQ-015 SHALL have rs1_busy_o / rs2_busy_o  output  1 each  source register has an outstanding load.
REQ-016 SHALL have rf_wen_o  output  1  register-file write enable.
REQ-017 SHALL have rf_waddr_o  output  5  register-file write address.
REQ-018 SHALL have rf_wdata_o  output  32  register-file write data.

Function
REQ-019 The block SHALL accept at most one request per cycle; alu_ready_o and lsu_ready_o SHALL never both be 1.
REQ-020 The ready outputs SHALL be combinational from the valid inputs and the arbiter state; a handshake completes when valid and ready are both 1.
REQ-021 The arbiter SHALL have two states: ALU_PRI (ALU wins ties) and LSU_FORCE (LSU wins ties).
REQ-022 If only one requester is valid, that requester SHALL be granted in either state.
REQ-023 Wait counter (width clog2(STARVE_LIMIT+1)): +1 per cycle with lsu_valid_i=1 and lsu_ready_o=0; cleared on LSU grant or on lsu_valid_i=0.
REQ-024 Transition ALU_PRI->LSU_FORCE SHALL occur when the counter reaches STARVE_LIMIT. Transition LSU_FORCE->ALU_PRI SHALL occur on LSU grant, or when lsu_valid_i=0 while in LSU_FORCE.
REQ-025 For an accepted request with rd!=0: rf_wen_o=1, rf_waddr_o=rd and rf_wdata_o=data SHALL appear on the next cycle for exactly one cycle (latency 1).
REQ-026 For an accepted request with rd=0: the handshake SHALL complete, rf_wen_o SHALL stay 0, and rf_waddr_o/rf_wdata_o SHALL hold their previous values.
REQ-027 In a cycle with no handshake, rf_wen_o SHALL be 0 on the following cycle; back-to-back grants SHALL give back-to-back writes.
REQ-028 Scoreboard pending[31:0]: load_issue_i with rd!=0 SHALL set pending[rd]; an accepted LSU request SHALL clear pending[lsu_rd_i]. Both take effect at the next edge.
REQ-029 If set and clear hit the same register in one cycle, set SHALL win; pending[0] SHALL always be 0.
REQ-030 rsN_busy_o = pending[rsN_addr_i] SHALL be combinational, with no bypass of same-cycle set or clear.
REQ-031 ALU grants SHALL NOT modify the scoreboard.

Reset
REQ-032 While rst_ni=0 at a clock edge: rf_wen_o=0, rf_waddr_o=0, rf_wdata_o=0, state=ALU_PRI, counter=0, pending=0.
REQ-033 While rst_ni=0: alu_ready_o=0 and lsu_ready_o=0, and no handshake SHALL be counted.
REQ-034 Reset asserted mid-operation SHALL discard the in-flight write; rf_wen_o SHALL be 0 on the cycle after the reset edge.
REQ-035 After reset, busy outputs SHALL read 0 until a new load_issue_i.

Structure
REQ-036 Shared package e10_pkg SHALL hold XLEN=32, REG_ADDR_W=5, NUM_REGS=32 and the arbiter state enum (ALU_PRI, LSU_FORCE).
REQ-037 The scoreboard SHALL be a sub-module rf_scoreboard, containing the set/clear logic and both busy lookups; arbitration and the write register stay in rf_wb_arbiter.
REQ-038 Target size SHALL be 150-250 RTL lines.

Verification
REQ-039 Single ALU: alu_valid=1, rd=5, data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle wen=1, waddr=5, wdata=0xDEADBEEF; the cycle after, wen=0.
REQ-040 Contention, STARVE_LIMIT=3: both valid continuously -> ALU granted cycles 0-2, LSU granted cycle 3, ALU granted cycle 4; lsu_ready is never 1 in the same cycle as alu_ready.
REQ-041 x0 write: lsu_valid=1, rd=0, data=0x1234 -> lsu_ready=1, wen stays 0, waddr/wdata unchanged.
REQ-042 Scoreboard: issue load rd=7 -> next cycle rs1_addr=7 gives rs1_busy=1; LSU writeback rd=7 accepted -> busy=0 next cycle; set and clear of rd=7 in the same cycle -> busy stays 1.
REQ-043 Reset mid-stream: grant ALU rd=9, drive rst_ni=0 on the next edge -> wen=0 after that edge; pending=0; both readies 0 while in reset.
REQ-044 Withdrawal: LSU waits 2 cycles, lsu_valid drops for 1 cycle -> counter returns to 0; a new LSU wait again needs 3 refusals before LSU_FORCE.

Source files
------------

// File: rtl/e10_pkg.sv
// Shared execute-stage definitions: register file geometry and the
// writeback arbiter state type.
package e10_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [0:0] {
    ALU_PRI   = 1'b0,
    LSU_FORCE = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rf_wb_if.sv
// Writeback request, load-issue and decode-lookup signals shared between
// the execute units and the register-file writeback arbiter.
interface rf_wb_if
  import e10_pkg::*;
  ();
  logic                  alu_valid_i;
  logic                  alu_ready_o;
  logic [REG_ADDR_W-1:0] alu_rd_i;
  logic [XLEN-1:0]       alu_data_i;
  logic                  lsu_valid_i;
  logic                  lsu_ready_o;
  logic [REG_ADDR_W-1:0] lsu_rd_i;
  logic [XLEN-1:0]       lsu_data_i;
  logic                  load_issue_i;
  logic [REG_ADDR_W-1:0] load_issue_rd_i;
  logic [REG_ADDR_W-1:0] rs1_addr_i;
  logic [REG_ADDR_W-1:0] rs2_addr_i;
  logic                  rs1_busy_o;
  logic                  rs2_busy_o;
  logic                  rf_wen_o;
  logic [REG_ADDR_W-1:0] rf_waddr_o;
  logic [XLEN-1:0]       rf_wdata_o;

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  lsu_valid_i, lsu_rd_i, lsu_data_i,
    input  load_issue_i, load_issue_rd_i, rs1_addr_i, rs2_addr_i,
    output alu_ready_o, lsu_ready_o, rs1_busy_o, rs2_busy_o,
    output rf_wen_o, rf_waddr_o, rf_wdata_o
  );

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output lsu_valid_i, lsu_rd_i, lsu_data_i,
    output load_issue_i, load_issue_rd_i, rs1_addr_i, rs2_addr_i,
    input  alu_ready_o, lsu_ready_o, rs1_busy_o, rs2_busy_o,
    input  rf_wen_o, rf_waddr_o, rf_wdata_o
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Outstanding-load scoreboard: one pending bit per register, set by load
// issue, cleared by load writeback, looked up by the decode stage.
module rf_scoreboard
  import e10_pkg::*;
  (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);
  localparam logic [NUM_REGS-1:0] X0_KEEP = {{(NUM_REGS-1){1'b1}}, 1'b0};

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_rd] = 1'b1;
    if (clr_en) clr_mask[clr_rd] = 1'b1;
  end

  // Set is applied after clear so a same-cycle reissue of the same rd wins.
  always_ff @(posedge clk) begin
    if (!rst_n) pending <= '0;
    else        pending <= ((pending & ~clr_mask) | set_mask) & X0_KEEP;
  end

  assign rs1_busy = pending[rs1_addr];
  assign rs2_busy = pending[rs2_addr];
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: ALU normally wins, but an LSU request
// refused STARVE_LIMIT cycles in a row is forced through on the next tie.
module rf_wb_arbiter
  import e10_pkg::*;
  #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  rf_wb_if.slave  bus
);
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             alu_hs, lsu_hs, lsu_refused;

  always_comb begin
    bus.alu_ready_o = 1'b0;
    bus.lsu_ready_o = 1'b0;
    if (rst_ni) begin
      if (bus.alu_valid_i && bus.lsu_valid_i) begin
        bus.lsu_ready_o = (state == LSU_FORCE);
        bus.alu_ready_o = (state != LSU_FORCE);
      end else begin
        bus.alu_ready_o = bus.alu_valid_i;
        bus.lsu_ready_o = bus.lsu_valid_i;
      end
    end
  end

  assign alu_hs      = bus.alu_valid_i & bus.alu_ready_o;
  assign lsu_hs      = bus.lsu_valid_i & bus.lsu_ready_o;
  assign lsu_refused = bus.lsu_valid_i & ~bus.lsu_ready_o;

  always_comb begin
    cnt_next   = cnt;
    state_next = state;
    if (!lsu_refused)       cnt_next = '0;
    else if (cnt != LIMIT)  cnt_next = cnt + CNT_W'(1);
    case (state)
      ALU_PRI:   if (lsu_refused && cnt_next == LIMIT) state_next = LSU_FORCE;
      LSU_FORCE: if (!bus.lsu_valid_i || lsu_hs)       state_next = ALU_PRI;
      default:   state_next = ALU_PRI;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= ALU_PRI;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Writes to x0 complete the handshake but leave address/data untouched.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bus.rf_wen_o   <= 1'b0;
      bus.rf_waddr_o <= '0;
      bus.rf_wdata_o <= '0;
    end else begin
      bus.rf_wen_o <= 1'b0;
      if (alu_hs && bus.alu_rd_i != '0) begin
        bus.rf_wen_o   <= 1'b1;
        bus.rf_waddr_o <= bus.alu_rd_i;
        bus.rf_wdata_o <= bus.alu_data_i;
      end else if (lsu_hs && bus.lsu_rd_i != '0) begin
        bus.rf_wen_o   <= 1'b1;
        bus.rf_waddr_o <= bus.lsu_rd_i;
        bus.rf_wdata_o <= bus.lsu_data_i;
      end
    end
  end

  rf_scoreboard u_sb (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .set_en   (bus.load_issue_i),
    .set_rd   (bus.load_issue_rd_i),
    .clr_en   (lsu_hs),
    .clr_rd   (bus.lsu_rd_i),
    .rs1_addr (bus.rs1_addr_i),
    .rs2_addr (bus.rs2_addr_i),
    .rs1_busy (bus.rs1_busy_o),
    .rs2_busy (bus.rs2_busy_o)
  );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed scenarios then random traffic,
// checked against a refusal-count / pending-set reference model.
module tb_rf_wb_arbiter;
  localparam int LIMIT = 3;

  typedef struct {
    bit          wen;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rf_wb_if bus ();

  rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  wr_t   expq[$];
  bit    m_pend[32];
  int    m_wait = 0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  string gseq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, check readies/busy, and queue the write expected after the edge.
  task automatic cyc(input bit r, input bit av, input logic [4:0] ard, input logic [31:0] ad,
                     input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                     input bit li, input logic [4:0] lird,
                     input logic [4:0] r1, input logic [4:0] r2);
    bit  ea, el;
    wr_t w;
    @(posedge clk); #1;
    rst_n = r;
    bus.alu_valid_i = av;  bus.alu_rd_i = ard; bus.alu_data_i = ad;
    bus.lsu_valid_i = lv;  bus.lsu_rd_i = lrd; bus.lsu_data_i = ld;
    bus.load_issue_i = li; bus.load_issue_rd_i = lird;
    bus.rs1_addr_i = r1;   bus.rs2_addr_i = r2;
    #2;
    // LSU loses a tie until it has been refused LIMIT cycles in a row.
    ea = r && av && (!lv || m_wait < LIMIT);
    el = r && lv && (!av || m_wait >= LIMIT);
    chk("alu_ready", 32'(bus.alu_ready_o), 32'(ea));
    chk("lsu_ready", 32'(bus.lsu_ready_o), 32'(el));
    if (bus.alu_ready_o && bus.lsu_ready_o) chk("ready_exclusive", 32'd1, 32'd0);
    chk("rs1_busy", 32'(bus.rs1_busy_o), 32'(m_pend[r1]));
    chk("rs2_busy", 32'(bus.rs2_busy_o), 32'(m_pend[r2]));
    gseq = {gseq, ea ? "A" : el ? "L" : "-"};

    w.wen = 1'b0;
    if (!r) begin
      m_wait = 0; m_addr = '0; m_data = '0;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
    end else begin
      m_wait = (lv && !el) ? m_wait + 1 : 0;
      if (ea && ard != 0) begin w.wen = 1'b1; m_addr = ard; m_data = ad; end
      if (el && lrd != 0) begin w.wen = 1'b1; m_addr = lrd; m_data = ld; end
      if (el) m_pend[lrd] = 1'b0;
      if (li) m_pend[lird] = 1'b1;
      m_pend[0] = 1'b0;
    end
    w.addr = m_addr;
    w.data = m_data;
    expq.push_back(w);
  endtask

  task automatic idle(input bit r);
    cyc(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: registered outputs after each edge against the queued expectation.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk); #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("rf_wen", 32'(bus.rf_wen_o), 32'(e.wen));
        chk("rf_waddr", 32'(bus.rf_waddr_o), 32'(e.addr));
        chk("rf_wdata", bus.rf_wdata_o, e.data);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.alu_valid_i = 0; bus.alu_rd_i = 0; bus.alu_data_i = 0;
    bus.lsu_valid_i = 0; bus.lsu_rd_i = 0; bus.lsu_data_i = 0;
    bus.load_issue_i = 0; bus.load_issue_rd_i = 0;
    bus.rs1_addr_i = 0; bus.rs2_addr_i = 0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    idle(0); idle(0); idle(1);

    // Single ALU write to r5.
    cyc(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    idle(1); idle(1);

    // Continuous contention: three ALU wins, then forced LSU, then ALU.
    gseq = "";
    for (int i = 0; i < 5; i++)
      cyc(1, 1, 5'(1 + i), 32'h100 + i, 1, 6, 32'h600 + i, 0, 0, 0, 0);
    chk("contention_seq", 32'(gseq == "AAALA"), 32'd1);
    idle(1);

    // LSU write to x0: handshake only, address/data hold.
    cyc(1, 0, 0, 0, 1, 0, 32'h1234, 0, 0, 0, 0);
    idle(1);

    // Scoreboard: issue r7, look up, retire it, then set+clear together.
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    cyc(1, 0, 0, 0, 1, 7, 32'h77, 0, 0, 7, 7);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    cyc(1, 0, 0, 0, 1, 7, 32'h78, 1, 7, 7, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7);
    chk("busy_set_wins", 32'(bus.rs1_busy_o), 32'd1);

    // Reset right after an ALU grant drops the write and the scoreboard.
    cyc(1, 1, 9, 32'h99, 0, 0, 0, 0, 0, 7, 0);
    cyc(0, 1, 9, 32'h9A, 1, 3, 32'h33, 0, 0, 7, 0);
    idle(1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);

    // Withdrawal after two refusals restarts the starvation count.
    gseq = "";
    cyc(1, 1, 1, 32'hA1, 1, 2, 32'hB1, 0, 0, 0, 0);
    cyc(1, 1, 1, 32'hA2, 1, 2, 32'hB2, 0, 0, 0, 0);
    cyc(1, 1, 1, 32'hA3, 0, 2, 32'hB3, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      cyc(1, 1, 1, 32'hA4 + i, 1, 2, 32'hB4 + i, 0, 0, 0, 0);
    chk("withdraw_seq", 32'(gseq == "AAAAAAL"), 32'd1);

    // Random traffic over a small register window to exercise scoreboard hits.
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 49) != 0,
          $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

    idle(1); idle(1);
    @(posedge clk); #3;
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
